// File: rtl/clock_pkg.sv
// Shared timekeeping types and constants for the digital clock counters.
// Used by the hour, minute and second counter blocks.
package clock_pkg;
   localparam int HOURS_PER_DAY = 24;
   localparam int HALF_DAY      = 12;
   localparam int HOUR_W        = 5;

   typedef logic [HOUR_W-1:0] hour_t;
   typedef logic [3:0]        bcd_digit_t;
endpackage

// File: rtl/hour_disp_map.sv
// Combinational map from binary hour to BCD display digits and PM flag.
// Handles both 12h (12,1..11) and 24h (00..23) presentation.
module hour_disp_map
   import clock_pkg::*;
(
   input  hour_t       hour,
   input  logic        mode24,
   output logic [1:0]  tens,
   output bcd_digit_t  ones,
   output logic        pm
);

   localparam hour_t HALF = hour_t'(HALF_DAY);

   hour_t disp;
   hour_t rem;

   always_comb begin
      pm   = (hour >= HALF);
      disp = hour;
      if (!mode24) begin
         // midnight reads 12 AM; afternoon folds back onto 1..11
         if (hour == '0) begin
            disp = HALF;
         end else if (hour > HALF) begin
            disp = hour - HALF;
         end
      end

      tens = 2'd0;
      rem  = disp;
      if (disp >= hour_t'(20)) begin
         tens = 2'd2;
         rem  = disp - hour_t'(20);
      end else if (disp >= hour_t'(10)) begin
         tens = 2'd1;
         rem  = disp - hour_t'(10);
      end
      ones = bcd_digit_t'(rem);
   end

endmodule

// File: rtl/hour_counter_cfg.sv
// Hour-of-day counter: 0..23 binary state, 12h/24h BCD display, AM/PM,
// time-set load with range check, manual advance and day-rollover carry.
module hour_counter_cfg
   import clock_pkg::*;
#(
   parameter int RESET_HOUR   = 0,
   parameter bit CARRY_ON_INC = 1'b0
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              tick_en,
   input  logic              inc_btn,
   input  logic              set_en,
   input  logic [HOUR_W-1:0] set_hour,
   input  logic              mode24,
   output logic [HOUR_W-1:0] hour_bin,
   output logic [1:0]        hour_tens,
   output logic [3:0]        hour_ones,
   output logic              AMPM,
   output logic              day_carry,
   output logic              set_err
);

   if (RESET_HOUR < 0 || RESET_HOUR >= HOURS_PER_DAY) begin : g_bad_reset_hour
      $error("RESET_HOUR must be in 0..23");
   end

   localparam hour_t RST_H = hour_t'(RESET_HOUR);
   localparam hour_t LAST  = hour_t'(HOURS_PER_DAY - 1);

   hour_t      nxt;
   hour_t      disp_in;
   logic       carry_n;
   logic       err_n;
   logic       wrap;
   logic [1:0] tens_n;
   bcd_digit_t ones_n;
   logic       pm_n;

   assign wrap = (hour_bin == LAST);

   always_comb begin
      nxt     = hour_bin;
      carry_n = 1'b0;
      err_n   = 1'b0;
      if (set_en) begin
         // an out-of-range load also swallows any coincident advance
         if (set_hour > LAST) begin
            err_n = 1'b1;
         end else begin
            nxt = set_hour;
         end
      end else if (tick_en || inc_btn) begin
         nxt     = wrap ? '0 : hour_bin + hour_t'(1);
         carry_n = wrap && (tick_en || (CARRY_ON_INC && inc_btn));
      end
   end

   assign disp_in = RST ? RST_H : nxt;

   hour_disp_map u_map (
      .hour   (disp_in),
      .mode24 (mode24),
      .tens   (tens_n),
      .ones   (ones_n),
      .pm     (pm_n)
   );

   always_ff @(posedge CLK) begin
      hour_tens <= tens_n;
      hour_ones <= ones_n;
      AMPM      <= pm_n;
      if (RST) begin
         hour_bin  <= RST_H;
         day_carry <= 1'b0;
         set_err   <= 1'b0;
      end else begin
         hour_bin  <= nxt;
         day_carry <= carry_n;
         set_err   <= err_n;
      end
   end

endmodule

// File: tb/tb_hour_counter_cfg.sv
// Scoreboard bench for hour_counter_cfg: two instances differing only in
// CARRY_ON_INC share all inputs; expectations come from a behavioural model.
module tb_hour_counter_cfg;

   typedef struct packed {
      logic [4:0] h;
      logic [1:0] t;
      logic [3:0] o;
      logic       pm;
      logic       c;
      logic       e;
   } obs_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       tick_en = 1'b0;
   logic       inc_btn = 1'b0;
   logic       set_en = 1'b0;
   logic [4:0] set_hour = '0;
   logic       mode24 = 1'b0;

   logic [4:0] hb0, hb1;
   logic [1:0] ht0, ht1;
   logic [3:0] ho0, ho1;
   logic       pm0, pm1, dc0, dc1, se0, se1;

   hour_counter_cfg #(.RESET_HOUR(0), .CARRY_ON_INC(1'b0)) dut0 (
      .CLK(CLK), .RST(RST), .tick_en(tick_en), .inc_btn(inc_btn),
      .set_en(set_en), .set_hour(set_hour), .mode24(mode24),
      .hour_bin(hb0), .hour_tens(ht0), .hour_ones(ho0), .AMPM(pm0),
      .day_carry(dc0), .set_err(se0)
   );

   hour_counter_cfg #(.RESET_HOUR(0), .CARRY_ON_INC(1'b1)) dut1 (
      .CLK(CLK), .RST(RST), .tick_en(tick_en), .inc_btn(inc_btn),
      .set_en(set_en), .set_hour(set_hour), .mode24(mode24),
      .hour_bin(hb1), .hour_tens(ht1), .hour_ones(ho1), .AMPM(pm1),
      .day_carry(dc1), .set_err(se1)
   );

   always #5 CLK = ~CLK;

   obs_t got0, got1;
   assign got0 = '{h: hb0, t: ht0, o: ho0, pm: pm0, c: dc0, e: se0};
   assign got1 = '{h: hb1, t: ht1, o: ho1, pm: pm1, c: dc1, e: se1};

   obs_t sb0[$];
   obs_t sb1[$];
   int   m_h = 0;
   int   n_chk = 0;
   int   n_err = 0;

   function automatic obs_t mk(int h, bit m, bit c, bit e);
      obs_t r;
      int   d;
      d = m ? h : ((h % 12 == 0) ? 12 : h % 12);
      r.h  = 5'(h);
      r.t  = 2'(d / 10);
      r.o  = 4'(d % 10);
      r.pm = (h >= 12);
      r.c  = c;
      r.e  = e;
      return r;
   endfunction

   task automatic step(input bit r, input bit t, input bit i,
                       input bit s, input int sh, input bit m);
      bit c0, c1, e;
      @(negedge CLK);
      RST = r; tick_en = t; inc_btn = i;
      set_en = s; set_hour = 5'(sh); mode24 = m;
      c0 = 0; c1 = 0; e = 0;
      if (r) begin
         m_h = 0;
      end else if (s) begin
         if (sh > 23) e = 1;
         else m_h = sh;
      end else if (t || i) begin
         c0 = (m_h == 23) && t;
         c1 = (m_h == 23);
         m_h = (m_h + 1) % 24;
      end
      sb0.push_back(mk(m_h, m, c0, e));
      sb1.push_back(mk(m_h, m, c1, e));
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      obs_t e;
      step(1, 1, 0, 0, 0, 0);
      e = sb0.pop_front(); void'(sb1.pop_front());
      n_chk++;
      if (got0 !== e) begin
         n_err++;
         $display("FAIL reset: got %h want %h", got0, e);
      end
   endtask

   task automatic test_tick_24h();
      obs_t e;
      step(0, 0, 0, 1, 22, 1);
      for (int k = 0; k < 4; k++) begin
         e = sb0.pop_front(); void'(sb1.pop_front());
         n_chk++;
         if (got0 !== e) begin
            n_err++;
            $display("FAIL tick24_%0d: got %h want %h", k, got0, e);
         end
         step(0, k < 2, 0, 0, 0, 1);
      end
      void'(sb0.pop_front()); void'(sb1.pop_front());
   endtask

   task automatic test_sweep_12h();
      obs_t e;
      step(0, 0, 0, 1, 0, 0);
      for (int k = 0; k < 25; k++) begin
         e = sb0.pop_front(); void'(sb1.pop_front());
         n_chk++;
         if (got0 !== e) begin
            n_err++;
            $display("FAIL sweep12_%0d: got %h want %h", k, got0, e);
         end
         step(0, 1, 0, 0, 0, 0);
      end
      void'(sb0.pop_front()); void'(sb1.pop_front());
   endtask

   task automatic test_set_priority();
      obs_t e;
      step(0, 0, 0, 1, 5, 1);
      void'(sb0.pop_front()); void'(sb1.pop_front());
      step(0, 1, 0, 1, 24, 1);
      for (int k = 0; k < 3; k++) begin
         e = sb0.pop_front(); void'(sb1.pop_front());
         n_chk++;
         if (got0 !== e) begin
            n_err++;
            $display("FAIL setpri_%0d: got %h want %h", k, got0, e);
         end
         if (k == 0) step(0, 1, 0, 1, 7, 1);
         else if (k == 1) step(0, 0, 0, 0, 0, 1);
      end
   endtask

   task automatic test_inc();
      obs_t e0, e1;
      step(0, 0, 0, 1, 23, 1);
      void'(sb0.pop_front()); void'(sb1.pop_front());
      step(0, 0, 1, 0, 0, 1);
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      n_chk++;
      if (got0 !== e0) begin
         n_err++;
         $display("FAIL inc_wrap_nocarry: got %h want %h", got0, e0);
      end
      n_chk++;
      if (got1 !== e1) begin
         n_err++;
         $display("FAIL inc_wrap_carry: got %h want %h", got1, e1);
      end
      step(0, 0, 0, 1, 3, 1);
      void'(sb0.pop_front()); void'(sb1.pop_front());
      step(0, 1, 1, 0, 0, 1);
      e0 = sb0.pop_front(); void'(sb1.pop_front());
      n_chk++;
      if (got0 !== e0) begin
         n_err++;
         $display("FAIL tick_plus_inc: got %h want %h", got0, e0);
      end
   endtask

   task automatic test_mode();
      obs_t e;
      step(0, 0, 0, 1, 15, 1);
      e = sb0.pop_front(); void'(sb1.pop_front());
      n_chk++;
      if (got0 !== e) begin
         n_err++;
         $display("FAIL mode_24: got %h want %h", got0, e);
      end
      step(0, 0, 0, 0, 0, 0);
      e = sb0.pop_front(); void'(sb1.pop_front());
      n_chk++;
      if (got0 !== e) begin
         n_err++;
         $display("FAIL mode_12: got %h want %h", got0, e);
      end
      step(0, 0, 0, 1, 23, 0);
      void'(sb0.pop_front()); void'(sb1.pop_front());
      step(1, 1, 1, 0, 0, 0);
      e = sb0.pop_front(); void'(sb1.pop_front());
      n_chk++;
      if (got0 !== e) begin
         n_err++;
         $display("FAIL rst_over_tick: got %h want %h", got0, e);
      end
   endtask

   task automatic test_back_to_back();
      obs_t e0, e1;
      for (int k = 0; k < 200; k++) begin
         step($urandom_range(0, 31) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0,
              int'($urandom_range(0, 31)),
              $urandom_range(0, 1) == 1);
         e0 = sb0.pop_front(); e1 = sb1.pop_front();
         n_chk++;
         if (got0 !== e0) begin
            n_err++;
            $display("FAIL rand0_%0d: got %h want %h", k, got0, e0);
         end
         n_chk++;
         if (got1 !== e1) begin
            n_err++;
            $display("FAIL rand1_%0d: got %h want %h", k, got1, e1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_tick_24h();
      test_sweep_12h();
      test_set_priority();
      test_inc();
      test_mode();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
